// File: rtl/led_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pkg: register map, blink state encoding and reset values. Rev 1.0
// ---------------------------------------------------------------------------
package led_pkg;

  localparam logic [1:0] ADDR_BRIGHT     = 2'd0;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd2;
  localparam logic [1:0] ADDR_STATUS     = 2'd3;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } blink_state_e;

  localparam logic [7:0]  RST_BRIGHT     = 8'hFF;
  localparam logic [7:0]  RST_BLINK_MASK = 8'h00;
  localparam logic [15:0] RST_BLINK_HALF = 16'h0000;
  localparam logic [7:0]  RST_BRIGHT_ACT = 8'h00;
  localparam logic [15:0] RST_FCNT       = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pwm_timebase: clk prescaler and 8-bit PWM frame counter. Rev 1.0
// ---------------------------------------------------------------------------
module led_pwm_timebase #(
  parameter int PRESCALE = 50
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic       frame_end,
  output logic [7:0] pwm_cnt
);

  localparam logic [15:0] c_PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] r_pre;
  logic [7:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (tick) begin
      r_pre <= '0;
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  // With PRESCALE=1 the terminal count is 0, so tick stays high every cycle.
  assign tick      = (r_pre == c_PRE_MAX);
  assign frame_end = tick && (r_cnt == 8'hFF);
  assign pwm_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/led_pwm_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pwm_driver: Avalon-MM LED PWM brightness and blink driver. Rev 1.0
// ---------------------------------------------------------------------------
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE       = 50,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam logic       c_INV     = (LED_ACTIVE_LOW != 0);
  localparam logic [7:0] c_LED_OFF = {8{c_INV}};

  logic [7:0]   r_bright;
  logic [7:0]   r_blink_mask;
  logic [15:0]  r_blink_half;
  logic [7:0]   r_bright_act;
  logic [15:0]  r_fcnt;
  blink_state_e r_state;

  blink_state_e w_state_nxt;
  logic [15:0]  w_fcnt_nxt;
  logic         w_wr;
  logic         w_wr_half;
  logic         w_tick;
  logic         w_frame_end;
  logic [7:0]   w_pwm_cnt;
  logic         w_pwm_on;
  logic [7:0]   w_lit;
  logic         w_unused;

  led_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .tick      (w_tick),
    .frame_end (w_frame_end),
    .pwm_cnt   (w_pwm_cnt)
  );

  assign w_wr      = chipselect && !write_n;
  assign w_wr_half = w_wr && (address == ADDR_BLINK_HALF);
  assign w_unused  = ^{writedata[31:16], w_tick};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bright     <= RST_BRIGHT;
      r_blink_mask <= RST_BLINK_MASK;
      r_blink_half <= RST_BLINK_HALF;
    end else if (w_wr) begin
      case (address)
        ADDR_BRIGHT:     r_bright     <= writedata[7:0];
        ADDR_BLINK_MASK: r_blink_mask <= writedata[7:0];
        ADDR_BLINK_HALF: r_blink_half <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Active brightness only changes on a frame boundary so a frame is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bright_act <= RST_BRIGHT_ACT;
    end else if (w_frame_end) begin
      r_bright_act <= r_bright;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ON;
      r_fcnt  <= RST_FCNT;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // A BLINK_HALF write restarts the blink cycle and wins over a coincident frame_end.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (w_wr_half || (r_blink_half == 16'd0)) begin
      w_state_nxt = ON;
      w_fcnt_nxt  = 16'd0;
    end else if (w_frame_end) begin
      if (r_fcnt == (r_blink_half - 16'd1)) begin
        w_state_nxt = (r_state == ON) ? OFF : ON;
        w_fcnt_nxt  = 16'd0;
      end else begin
        w_fcnt_nxt  = r_fcnt + 16'd1;
      end
    end
  end

  assign w_pwm_on = (w_pwm_cnt < r_bright_act);
  assign w_lit    = led_in & {8{w_pwm_on}} & (~r_blink_mask | {8{r_state == ON}});

  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= c_LED_OFF;
    end else begin
      led_out <= w_lit ^ c_LED_OFF;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_BRIGHT:     readdata[7:0]  = r_bright;
      ADDR_BLINK_MASK: readdata[7:0]  = r_blink_mask;
      ADDR_BLINK_HALF: readdata[15:0] = r_blink_half;
      default:         readdata[8:0]  = {(r_state == ON), r_bright_act};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_pwm_driver: directed self-checking bench for led_pwm_driver. Rev 1.0
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;
  import led_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  led_in_a = 8'h00;
  logic [7:0]  led_in_b = 8'hFF;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [7:0]  led_a;
  logic [7:0]  led_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  led_pwm_driver #(.PRESCALE(1), .LED_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .reset(reset), .led_in(led_in_a), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd_a), .led_out(led_a)
  );

  led_pwm_driver #(.PRESCALE(2), .LED_ACTIVE_LOW(1)) u_dut_p2 (
    .clk(clk), .reset(reset), .led_in(led_in_b), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd_b), .led_out(led_b)
  );

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = rd_a;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  exp;
    apply_reset();
    n_checks++; if (led_b !== 8'hFF) begin n_fail++; $display("FAIL reset_led_p2: got %h expected ff", led_b); end
    n_checks++; if (led_a !== 8'hFF) begin n_fail++; $display("FAIL reset_led: got %h expected ff", led_a); end
    bus_read(ADDR_BRIGHT, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL reset_bright: got %h expected 000000ff", d); end
    bus_read(ADDR_BLINK_MASK, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h expected 00000000", d); end
    bus_read(ADDR_BLINK_HALF, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_half: got %h expected 00000000", d); end
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL reset_status: got %h expected 00000100", d); end
    reset = 1'b0;
    cyc = 0;
    // PRESCALE=2: first frame_end is edge 512, led_out follows one edge later.
    while (cyc < 520) begin
      step();
      exp = (cyc >= 513) ? 8'h00 : 8'hFF;
      n_checks++; if (led_b !== exp) begin n_fail++; $display("FAIL reset_frame0 cyc %0d: got %h expected %h", cyc, led_b, exp); end
    end
  endtask

  task automatic test_pwm_duty();
    int lows;
    int upper_bad;
    apply_reset();
    reset = 1'b0;
    cyc = 0;
    led_in_a = 8'h01;
    bus_write(ADDR_BRIGHT, 32'h40);
    run_to(256);
    n_checks++; if (led_a !== 8'hFF) begin n_fail++; $display("FAIL duty_dark_frame: got %h expected ff", led_a); end
    lows = 0;
    upper_bad = 0;
    while (cyc < 512) begin
      step();
      if (led_a[0] == 1'b0) lows++;
      if (led_a[7:1] !== 7'h7F) upper_bad++;
      if (cyc == 257) begin
        n_checks++; if (led_a !== 8'hFE) begin n_fail++; $display("FAIL duty_first_on: got %h expected fe", led_a); end
      end
      if (cyc == 320) begin
        n_checks++; if (led_a !== 8'hFE) begin n_fail++; $display("FAIL duty_last_on: got %h expected fe", led_a); end
      end
      if (cyc == 321) begin
        n_checks++; if (led_a !== 8'hFF) begin n_fail++; $display("FAIL duty_first_off: got %h expected ff", led_a); end
      end
    end
    n_checks++; if (lows != 64) begin n_fail++; $display("FAIL duty_count: got %0d expected 64", lows); end
    n_checks++; if (upper_bad != 0) begin n_fail++; $display("FAIL duty_upper_bits: got %0d bad cycles expected 0", upper_bad); end
  endtask

  task automatic test_glitch_free();
    logic [31:0] d;
    int lows;
    apply_reset();
    reset = 1'b0;
    cyc = 0;
    led_in_a = 8'h01;
    run_to(384);
    bus_write(ADDR_BRIGHT, 32'h10);
    n_checks++; if (led_a !== 8'hFE) begin n_fail++; $display("FAIL glitch_mid_frame: got %h expected fe", led_a); end
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d[7:0] !== 8'hFF) begin n_fail++; $display("FAIL glitch_status_before: got %h expected ff", d[7:0]); end
    run_to(511);
    n_checks++; if (led_a !== 8'hFE) begin n_fail++; $display("FAIL glitch_frame_tail: got %h expected fe", led_a); end
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d[7:0] !== 8'hFF) begin n_fail++; $display("FAIL glitch_status_pre_end: got %h expected ff", d[7:0]); end
    run_to(512);
    n_checks++; if (led_a !== 8'hFF) begin n_fail++; $display("FAIL glitch_cnt255_off: got %h expected ff", led_a); end
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d[7:0] !== 8'h10) begin n_fail++; $display("FAIL glitch_status_after: got %h expected 10", d[7:0]); end
    lows = 0;
    while (cyc < 768) begin
      step();
      if (led_a[0] == 1'b0) lows++;
    end
    n_checks++; if (lows != 16) begin n_fail++; $display("FAIL glitch_next_frame: got %0d expected 16", lows); end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    int          pts [6]    = '{384, 640, 896, 1152, 1408, 1664};
    logic [7:0]  exp_led [6] = '{8'hFC, 8'hFC, 8'hFE, 8'hFE, 8'hFE, 8'hFC};
    logic [31:0] exp_st [6]  = '{32'h1FF, 32'h1FF, 32'h0FF, 32'h0FF, 32'h0FF, 32'h1FF};
    apply_reset();
    reset = 1'b0;
    cyc = 0;
    led_in_a = 8'h03;
    bus_write(ADDR_BLINK_MASK, 32'h02);
    bus_write(ADDR_BLINK_HALF, 32'h03);
    for (int i = 0; i < 6; i++) begin
      run_to(pts[i]);
      n_checks++; if (led_a !== exp_led[i]) begin n_fail++; $display("FAIL blink_led cyc %0d: got %h expected %h", cyc, led_a, exp_led[i]); end
      bus_read(ADDR_STATUS, d);
      n_checks++; if (d !== exp_st[i]) begin n_fail++; $display("FAIL blink_status cyc %0d: got %h expected %h", cyc, d, exp_st[i]); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    // Edge 2304 is the frame_end that would turn phase OFF.
    run_to(2303);
    bus_write(ADDR_BLINK_HALF, 32'h03);
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d[8] !== 1'b1) begin n_fail++; $display("FAIL collision_phase: got %b expected 1", d[8]); end
    run_to(2432);
    n_checks++; if (led_a !== 8'hFC) begin n_fail++; $display("FAIL collision_led: got %h expected fc", led_a); end
    run_to(3000);
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d !== 32'h1FF) begin n_fail++; $display("FAIL collision_hold: got %h expected 000001ff", d); end
    run_to(3200);
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d !== 32'h0FF) begin n_fail++; $display("FAIL collision_retoggle: got %h expected 000000ff", d); end
    n_checks++; if (led_a !== 8'hFE) begin n_fail++; $display("FAIL collision_led_off: got %h expected fe", led_a); end
  endtask

  task automatic test_midblink_reset();
    logic [31:0] d;
    @(negedge clk);
    reset = 1'b1;
    address = ADDR_BRIGHT; writedata = 32'h55; chipselect = 1'b1; write_n = 1'b0;
    repeat (3) @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    n_checks++; if (led_a !== 8'hFF) begin n_fail++; $display("FAIL midreset_led: got %h expected ff", led_a); end
    reset = 1'b0;
    cyc = 0;
    bus_read(ADDR_BRIGHT, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL midreset_bright: got %h expected 000000ff", d); end
    bus_read(ADDR_BLINK_MASK, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_mask: got %h expected 00000000", d); end
    bus_read(ADDR_BLINK_HALF, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_half: got %h expected 00000000", d); end
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL midreset_status: got %h expected 00000100", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(ADDR_BRIGHT, 32'hABCDEF33);
    bus_read(ADDR_BRIGHT, d);
    n_checks++; if (d !== 32'h33) begin n_fail++; $display("FAIL regs_bright: got %h expected 00000033", d); end
    bus_write(ADDR_BLINK_MASK, 32'h12345678);
    bus_read(ADDR_BLINK_MASK, d);
    n_checks++; if (d !== 32'h78) begin n_fail++; $display("FAIL regs_mask: got %h expected 00000078", d); end
    bus_write(ADDR_BLINK_HALF, 32'hDEADBEEF);
    bus_read(ADDR_BLINK_HALF, d);
    n_checks++; if (d !== 32'hBEEF) begin n_fail++; $display("FAIL regs_half: got %h expected 0000beef", d); end
    bus_write(ADDR_STATUS, 32'hFFFFFFFF);
    bus_read(ADDR_STATUS, d);
    n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL regs_status_ro: got %h expected 00000100", d); end
  endtask

  initial begin
    test_reset();
    test_pwm_duty();
    test_glitch_free();
    test_blink();
    test_collision();
    test_midblink_reset();
    test_regs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 50, sets the number of clk cycles per PWM tick; legal range is 1..65535.
REQ-002 Parameter LED_ACTIVE_LOW, default 1; when 1, led_out is inverted so that 0 lights the LED.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port led_in, input, 8 bits: per-LED enable, driven by the LED PIO out_port.
REQ-007 Port address, input, 2 bits: Avalon-MM slave register select.
REQ-008 Port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-009 Port write_n, input, 1 bit: active-low write strobe.
REQ-010 Port writedata, input, 32 bits: Avalon-MM write data.
REQ-011 Port readdata, output, 32 bits: Avalon-MM read data, zero wait states.
REQ-012 Port led_out, output, 8 bits: registered drive to the physical LED pins.

Function
REQ-013 A register write occurs in a cycle where chipselect=1 and write_n=0.
REQ-014 Register map: addr0 BRIGHT[7:0]; addr1 BLINK_MASK[7:0]; addr2 BLINK_HALF[15:0] (half-period in PWM frames); addr3 STATUS (read-only, writes ignored).
REQ-015 Unused writedata bits are ignored; unused readdata bits read 0.
REQ-016 readdata is combinational from address: BRIGHT, BLINK_MASK, BLINK_HALF, or STATUS = {23'b0, phase, bright_act[7:0]}.
REQ-017 Prescaler: tick is asserted for exactly 1 cycle every PRESCALE cycles; with PRESCALE=1, tick is asserted every cycle.
REQ-018 pwm_cnt (8 bits) increments on each tick and wraps 255->0; that wrap cycle is frame_end.
REQ-019 bright_act loads BRIGHT at frame_end only, so a mid-frame BRIGHT write never glitches the current frame.
REQ-020 pwm_on = (pwm_cnt < bright_act).
REQ-021 BRIGHT=0 gives LEDs always off; BRIGHT=255 gives 255/256 duty.
REQ-022 Blink FSM: two states, ON (phase=1) and OFF (phase=0), plus a 16-bit frame counter fcnt.
REQ-023 At frame_end with BLINK_HALF != 0: if fcnt == BLINK_HALF-1, toggle phase and clear fcnt; otherwise increment fcnt.
REQ-024 BLINK_HALF=0 disables blinking: phase is forced to ON and fcnt is held at 0.
REQ-025 A write to BLINK_HALF clears fcnt and sets phase=ON in the same cycle; this write takes priority over a simultaneous frame_end.
REQ-026 lit[i] = led_in[i] & pwm_on & (~BLINK_MASK[i] | phase).
REQ-027 led_out <= lit XOR {8{LED_ACTIVE_LOW}}, registered.
REQ-028 Latency from a change on led_in or pwm_on to led_out is exactly 1 clk.
REQ-029 Register writes take effect on the next clk edge.
REQ-030 The PWM path uses the new BRIGHT value from the next frame_end onward.

Reset
REQ-031 While reset=1 at a clk edge, the block SHALL load: BRIGHT=0xFF, BLINK_MASK=0x00, BLINK_HALF=0, bright_act=0, phase=ON, fcnt=0, pwm_cnt=0, prescaler=0.
REQ-032 led_out SHALL reset to the LED-off state: 0xFF when LED_ACTIVE_LOW=1, 0x00 otherwise.
REQ-033 Reset asserted mid-frame or mid-blink SHALL abort the frame or blink immediately.
REQ-034 After reset, the first frame is dark (bright_act=0).
REQ-035 From the second frame onward, LEDs follow led_in at BRIGHT=0xFF.
REQ-036 Writes are ignored while reset=1.

Structure
REQ-037 A shared package led_pkg SHALL hold the register address constants (ADDR_BRIGHT=0, ADDR_BLINK_MASK=1, ADDR_BLINK_HALF=2, ADDR_STATUS=3).
REQ-038 led_pkg SHALL hold the blink state encoding (ON, OFF) and the reset constants.
REQ-039 The prescaler plus pwm_cnt SHALL be one sub-module, led_pwm_timebase, with outputs tick, frame_end and pwm_cnt.
REQ-040 The register file, blink FSM and output logic SHALL stay in the top-level module.

Verification
REQ-041 Reset check: PRESCALE=2, LED_ACTIVE_LOW=1, reset high for 3 cycles, led_in=0xFF -> led_out=0xFF during frame 0, then 0x00 from the cycle after the first frame_end plus 1.
REQ-042 PWM duty: BRIGHT=0x40, led_in=0x01, PRESCALE=1 -> led_out[0] low for exactly 64 of every 256 cycles; bits 7:1 constantly 1.
REQ-043 Glitch-free update: write BRIGHT=0x10 at pwm_cnt=0x80 -> current frame duty is unchanged; next frame on-time is 16 ticks; STATUS[7:0] reads 0x10 only after frame_end.
REQ-044 Blink: BLINK_MASK=0x02, BLINK_HALF=3, led_in=0x03, BRIGHT=0xFF -> LED1 alternates 3 frames lit and 3 frames dark; LED0 never blinks; STATUS[8] toggles every 3 frames.
REQ-045 Collision: write BLINK_HALF=3 in the same cycle as the frame_end that would toggle phase -> phase=ON, fcnt=0, no toggle.
REQ-046 Mid-blink reset: reset during the OFF phase -> phase=ON, BLINK_MASK=0, and all registers read their reset values on the next read.
